// File: rtl/serial_receiver.sv
// serial_receiver: 8N1 UART receiver with a two-flop input synchronizer and
// mid-bit sampling driven by a per-bit tick timer.
// Optional feature: define SERIAL_RECEIVER_FRAME_ERROR_EN to add the
// oFrameError output (one-cycle pulse on a bad stop bit).
module serial_receiver #(
    parameter int unsigned ClockFrequency = 16000000,
    parameter int unsigned BaudRate       = 115200
) (
    input  logic       iClock,
    input  logic       iReset,
    input  logic       iRXD,
    output logic [7:0] oData,
    output logic       oReceived
`ifdef SERIAL_RECEIVER_FRAME_ERROR_EN
    ,
    output logic       oFrameError
`endif
);

    localparam int unsigned TicksPerBit = ClockFrequency / BaudRate;
    localparam int unsigned HalfTicks   = TicksPerBit / 2;
    localparam int unsigned TimerW      = $clog2(TicksPerBit);

    localparam logic [TimerW-1:0] BitEnd  = TimerW'(TicksPerBit - 1);
    localparam logic [TimerW-1:0] HalfEnd = TimerW'(HalfTicks - 1);
    localparam logic [TimerW-1:0] TimerOne = TimerW'(1);

    typedef enum logic [2:0] {
        sIdle,
        sStartBit,
        sDataBit,
        sStopBit,
        sWaitHigh
    } state_e;

    state_e            state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        data_q, data_d;
    logic              received_q, received_d;
    logic [1:0]        sync_q;
    logic              rx_s;

`ifdef SERIAL_RECEIVER_FRAME_ERROR_EN
    logic              frame_err_q, frame_err_d;
`endif

    assign rx_s = sync_q[1];

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], iRXD};
        end
    end

    // State, timer, shift register and registered outputs.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q     <= sIdle;
            timer_q     <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            received_q  <= 1'b0;
`ifdef SERIAL_RECEIVER_FRAME_ERROR_EN
            frame_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            received_q  <= received_d;
`ifdef SERIAL_RECEIVER_FRAME_ERROR_EN
            frame_err_q <= frame_err_d;
`endif
        end
    end

    // Next-state logic; the timer restarts at every sample point so it never wraps.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        received_d  = 1'b0;
`ifdef SERIAL_RECEIVER_FRAME_ERROR_EN
        frame_err_d = 1'b0;
`endif
        unique case (state_q)
            sIdle: begin
                if (!rx_s) begin
                    state_d = sStartBit;
                    timer_d = '0;
                end
            end
            sStartBit: begin
                if (timer_q == HalfEnd) begin
                    timer_d = '0;
                    if (rx_s) begin
                        // Start bit did not survive to mid-bit: treat as a glitch.
                        state_d = sIdle;
                    end else begin
                        state_d   = sDataBit;
                        bit_idx_d = '0;
                    end
                end else begin
                    timer_d = timer_q + TimerOne;
                end
            end
            sDataBit: begin
                if (timer_q == BitEnd) begin
                    timer_d = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = sStopBit;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + TimerOne;
                end
            end
            sStopBit: begin
                if (timer_q == BitEnd) begin
                    timer_d = '0;
                    if (rx_s) begin
                        data_d     = shift_q;
                        received_d = 1'b1;
                        // Back to idle at mid-stop so a zero-gap start bit is caught.
                        state_d    = sIdle;
                    end else begin
`ifdef SERIAL_RECEIVER_FRAME_ERROR_EN
                        frame_err_d = 1'b1;
`endif
                        state_d = sWaitHigh;
                    end
                end else begin
                    timer_d = timer_q + TimerOne;
                end
            end
            sWaitHigh: begin
                // Hold off through a break until the line returns high.
                if (rx_s) begin
                    state_d = sIdle;
                end
            end
            default: begin
                state_d = sIdle;
            end
        endcase
    end

    assign oData     = data_q;
    assign oReceived = received_q;
`ifdef SERIAL_RECEIVER_FRAME_ERROR_EN
    assign oFrameError = frame_err_q;
`endif

endmodule

// File: tb/tb_serial_receiver.sv
// tb_serial_receiver: directed bench for serial_receiver at 16 MHz / 1 Mbaud
// (16 clocks per bit). A bench-side serializer stands in for the transmitter.
module tb_serial_receiver;

    localparam int unsigned Tpb = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic [7:0] data;
    logic       received;
`ifdef SERIAL_RECEIVER_FRAME_ERROR_EN
    logic       frame_err;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int rx_cnt      = 0;
    int fe_cnt      = 0;
    int both_cnt    = 0;
    int rx_cyc      = 0;
    int start_cyc   = 0;
    logic [7:0] rx_q[$];

    serial_receiver #(
        .ClockFrequency(16000000),
        .BaudRate      (1000000)
    ) dut (
        .iClock     (clk),
        .iReset     (rst),
        .iRXD       (rxd),
        .oData      (data),
        .oReceived  (received)
`ifdef SERIAL_RECEIVER_FRAME_ERROR_EN
        ,
        .oFrameError(frame_err)
`endif
    );

    always #5 clk = ~clk;

    // Count rising edges.
    always @(posedge clk) cyc++;

    // Record output pulses away from the active edge.
    always @(negedge clk) begin
        if (received) begin
            rx_cnt++;
            rx_q.push_back(data);
            rx_cyc = cyc;
        end
`ifdef SERIAL_RECEIVER_FRAME_ERROR_EN
        if (frame_err) begin
            fe_cnt++;
            if (received) both_cnt++;
        end
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        repeat (Tpb) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        start_cyc = cyc + 1;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data", {24'h0, data}, 32'h00);
        check("reset_received", {31'h0, received}, 32'h0);
`ifdef SERIAL_RECEIVER_FRAME_ERROR_EN
        check("reset_frame_err", {31'h0, frame_err}, 32'h0);
`endif
        rst = 1'b0;
        idle(5);

        // Single frame 0xA5 with latency check (154 edges; 155 +/- 1 allowed).
        send_byte(8'hA5, 1'b1);
        idle(8);
        check("a5_count", rx_cnt, 1);
        check("a5_data", {24'h0, data}, 32'hA5);
        check("a5_latency_in_range",
              {31'h0, ((rx_cyc - start_cyc) >= 154) && ((rx_cyc - start_cyc) <= 156)}, 32'h1);

        // Four-cycle low glitch: rejected at mid-start.
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        idle(40);
        check("glitch_count", rx_cnt, 1);
        check("glitch_data", {24'h0, data}, 32'hA5);

        // Good 0x3C, then 0x81 with a low stop bit and a 40-cycle break, then 0x42.
        send_byte(8'h3C, 1'b1);
        idle(8);
        check("3c_data", {24'h0, data}, 32'h3C);
        start_cyc = cyc + 1;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(i == 0 || i == 7);
        rxd = 1'b0;
        repeat (Tpb + 40) @(negedge clk);
        idle(20);
        check("break_count", rx_cnt, 2);
        check("break_data", {24'h0, data}, 32'h3C);
`ifdef SERIAL_RECEIVER_FRAME_ERROR_EN
        check("break_frame_err_count", fe_cnt, 1);
`endif
        send_byte(8'h42, 1'b1);
        idle(8);
        check("42_count", rx_cnt, 3);
        check("42_data", {24'h0, data}, 32'h42);

        // Back-to-back 0x00 and 0xFF with no idle gap.
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        idle(8);
        check("b2b_count", rx_cnt, 5);
        check("b2b_first", {24'h0, rx_q[3]}, 32'h00);
        check("b2b_second", {24'h0, rx_q[4]}, 32'hFF);

        // Reset during data bit 3 of 0x5A aborts the frame and clears oData.
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        rxd = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(200);
        check("abort_count", rx_cnt, 5);
        check("abort_data", {24'h0, data}, 32'h00);
        send_byte(8'hC3, 1'b1);
        idle(8);
        check("c3_count", rx_cnt, 6);
        check("c3_data", {24'h0, data}, 32'hC3);

        // Consecutive transmitter stream 0x55, 0xAA, 0x0F.
        send_byte(8'h55, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'h0F, 1'b1);
        idle(20);
        check("loop_count", rx_cnt, 9);
        check("loop_first", {24'h0, rx_q[6]}, 32'h55);
        check("loop_second", {24'h0, rx_q[7]}, 32'hAA);
        check("loop_third", {24'h0, rx_q[8]}, 32'h0F);
        check("frame_err_total", fe_cnt,
`ifdef SERIAL_RECEIVER_FRAME_ERROR_EN
              1
`else
              0
`endif
        );
        check("no_simultaneous_pulses", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_receiver.md
SERIAL_RECEIVER -- requirements
Module: serial_receiver

Interface
REQ-001 SHALL have parameter ClockFrequency, default 16000000, meaning top-level clock frequency in Hz.
REQ-002 SHALL have parameter BaudRate, default 115200, meaning serial bit rate; BaudRate <= ClockFrequency/4.
REQ-003 SHALL have port iClock  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port iReset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port iRXD  input  1  asynchronous UART receive line, idle high, 8N1, LSB first.
REQ-006 SHALL have port oData  output  8  last correctly framed byte.
REQ-007 SHALL have port oReceived  output  1  one-cycle pulse when oData is updated.
REQ-008 SHALL have port oFrameError  output  1  one-cycle pulse on bad stop bit, present only when SERIAL_RECEIVER_FRAME_ERROR_EN is defined.

Function
REQ-009 SHALL compute TicksPerBit = ClockFrequency/BaudRate (integer) and HalfTicks = TicksPerBit/2.
REQ-010 SHALL pass iRXD through a two-flop synchronizer; the state machine uses only the second flop (RxS).
REQ-011 SHALL implement states sIdle, sStartBit, sDataBit, sStopBit, sWaitHigh.
REQ-012 sIdle: RxS == 0 -> sStartBit with bit timer cleared to 0; otherwise remain.
REQ-013 sStartBit: when timer reaches HalfTicks-1, sample RxS; 1 -> sIdle (glitch, no output); 0 -> sDataBit, timer cleared, bit index 0.
REQ-014 sDataBit: when timer reaches TicksPerBit-1, sample RxS into shift register MSB, shifting right; after 8th sample -> sStopBit, timer cleared.
REQ-015 sStopBit: when timer reaches TicksPerBit-1, sample RxS; 1 -> load oData from shift register, pulse oReceived, go sIdle; 0 -> pulse oFrameError (if enabled), go sWaitHigh.
REQ-016 sWaitHigh: remain until RxS == 1, then sIdle; break conditions SHALL NOT produce oReceived.
REQ-017 Sampling points SHALL therefore lie at mid-bit for start, data and stop bits; the receiver returns to sIdle at mid-stop so a following start bit with zero idle gap is detected.
REQ-018 oReceived SHALL assert exactly 3 + HalfTicks + 9*TicksPerBit cycles (+/-1) after the first rising edge on which iRXD is low.
REQ-019 oData SHALL hold its value between valid frames and SHALL NOT change on glitch, framing error or reset-free abort.
REQ-020 oReceived and oFrameError SHALL never assert in the same cycle and SHALL be high for exactly one cycle per event.
REQ-021 Bit timer width SHALL be $clog2(TicksPerBit) bits; no wrap-around occurs since it is cleared at each sample point.

Reset
REQ-022 iReset high SHALL force: state sIdle, timer 0, bit index 0, synchronizer flops 1, oData 8'h00, oReceived 0, oFrameError 0.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no output pulse; reception restarts on the next falling edge after release.
REQ-024 Reset SHALL take priority over every other state transition.

Configuration
REQ-025 With SERIAL_RECEIVER_FRAME_ERROR_EN defined, port oFrameError SHALL exist and pulse per REQ-015.
REQ-026 Without SERIAL_RECEIVER_FRAME_ERROR_EN, port oFrameError SHALL be absent; bad stop bit SHALL still go to sWaitHigh silently.

Verification (ClockFrequency=16000000, BaudRate=1000000, TicksPerBit=16)
REQ-027 Drive 8N1 frame 0xA5 on iRXD -> single oReceived pulse, oData=0xA5, at latency per REQ-018.
REQ-028 Drive iRXD low for 4 cycles then high -> no oReceived, state returns to sIdle, oData unchanged.
REQ-029 Receive 0x3C, then frame 0x81 with stop bit 0 and line held low 40 cycles -> no oReceived, oData stays 0x3C, oFrameError one pulse (macro defined); next frame 0x42 received normally.
REQ-030 Back-to-back 0x00 then 0xFF, zero idle between stop and start -> two oReceived pulses, oData 0x00 then 0xFF.
REQ-031 Assert iReset during data bit 3 of 0x5A -> no pulse, oData=0x00; after release frame 0xC3 -> oData=0xC3.
REQ-032 Loopback from SerialTransmitter oTXD sending 0x55, 0xAA, 0x0F consecutively -> three pulses with matching oData in order.
